// File: rtl/intra_4x4_dec_pe_pkg.sv
// -----------------------------------------------------------------------------
// intra_4x4_dec_pe_pkg
// Shared definitions for the intra 4x4 decode processing element:
//   - FSM state encoding (IDLE, DEQ, ROW, COL, RECON, OUT)
//   - datapath widths: coefficient 15, dequantised 16, transform 20 bits
//   - default quantizer (27) used when the qp port is not built
//   - dequant scale table LS[class][qp%6] and helpers
// Build macro consumed by the top: INTRA4X4_DEC_QP_PORT_EN (adds qp_i port).
// No ports (package).
// -----------------------------------------------------------------------------
package intra_4x4_dec_pe_pkg;

   typedef enum logic [2:0] {IDLE, DEQ, ROW, COL, RECON, OUT} state_t;

   localparam int COEF_W = 15;
   localparam int DEQ_W  = 16;
   localparam int TR_W   = 20;

   localparam logic [5:0] DEFAULT_QP = 6'd27;

   // Row index = position class: 0 (i,j both even), 1 (both odd), 2 (mixed).
   localparam logic [4:0] LS_TAB [0:2][0:5] = '{
      '{5'd10, 5'd11, 5'd13, 5'd14, 5'd16, 5'd18},
      '{5'd16, 5'd18, 5'd20, 5'd23, 5'd25, 5'd29},
      '{5'd13, 5'd14, 5'd16, 5'd18, 5'd20, 5'd23}
   };

   function automatic logic [1:0] pos_class(input int i, input int j);
      if ((i % 2 == 0) && (j % 2 == 0))
         return 2'd0;
      else if ((i % 2 == 1) && (j % 2 == 1))
         return 2'd1;
      else
         return 2'd2;
   endfunction

   // Largest product is 16384*29*256, well inside 32 bits, so the
   // saturation test on the full product is exact.
   function automatic logic signed [DEQ_W-1:0] dequant(
      input logic signed [COEF_W-1:0] c,
      input logic [4:0]               ls,
      input logic [3:0]               sh
   );
      logic signed [31:0] prod;
      prod = (32'(c) * $signed({27'd0, ls})) <<< sh;
      if (prod > 32'sd32767)
         return 16'sh7fff;
      else if (prod < -32'sd32768)
         return 16'sh8000;
      else
         return prod[DEQ_W-1:0];
   endfunction

endpackage

// File: rtl/intra_4x4_idct1d.sv
// -----------------------------------------------------------------------------
// intra_4x4_idct1d
// One 4-point H.264 inverse core transform butterfly, purely combinational.
// The top uses four of these for a whole row pass, then again for the column
// pass.
// Ports:
//   i_x0..i_x3  in  TR_W signed  butterfly inputs
//   o_y0..o_y3  out TR_W signed  butterfly outputs
// -----------------------------------------------------------------------------
module intra_4x4_idct1d
   import intra_4x4_dec_pe_pkg::*;
(
   input  logic signed [TR_W-1:0] i_x0,
   input  logic signed [TR_W-1:0] i_x1,
   input  logic signed [TR_W-1:0] i_x2,
   input  logic signed [TR_W-1:0] i_x3,
   output logic signed [TR_W-1:0] o_y0,
   output logic signed [TR_W-1:0] o_y1,
   output logic signed [TR_W-1:0] o_y2,
   output logic signed [TR_W-1:0] o_y3
);

   logic signed [TR_W-1:0] w_e0;
   logic signed [TR_W-1:0] w_e1;
   logic signed [TR_W-1:0] w_e2;
   logic signed [TR_W-1:0] w_e3;

   assign w_e0 = i_x0 + i_x2;
   assign w_e1 = i_x0 - i_x2;
   assign w_e2 = (i_x1 >>> 1) - i_x3;
   assign w_e3 = i_x1 + (i_x3 >>> 1);

   assign o_y0 = w_e0 + w_e3;
   assign o_y1 = w_e1 + w_e2;
   assign o_y2 = w_e1 - w_e2;
   assign o_y3 = w_e0 - w_e3;

endmodule

// File: rtl/intra_4x4_dec_pe.sv
// -----------------------------------------------------------------------------
// intra_4x4_dec_pe
// Intra 4x4 block decoder: DC prediction, dequantisation, 2-pass inverse core
// transform, rounding and clipped reconstruction. One block in flight.
// Build macro: INTRA4X4_DEC_QP_PORT_EN -- when defined, qp_i is a port sampled
// at accept; otherwise qp is fixed at 27.
// Ports:
//   clk                         in   rising-edge clock
//   rst                         in   asynchronous reset, active low
//   h264_reset                  in   synchronous soft clear, active high
//   coef_valid / coef_ready     in/out  coefficient handshake (ready in IDLE)
//   coef [0:3][0:3] x15 signed  in   quantized levels, raster order
//   A,B,C,D / I,J,K,L  x8       in   top / left neighbour pixels
//   mbAddrA_valid, mbAddrB_valid in  left / top availability
//   qp_i x6                     in   quantizer 0..51 (macro builds only)
//   recon_valid / recon_ready   out/in  output handshake (valid in OUT)
//   recon [0:3][0:3] x8         out  reconstructed pixels
// -----------------------------------------------------------------------------
module intra_4x4_dec_pe
   import intra_4x4_dec_pe_pkg::*;
(
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               h264_reset,
   input  logic                               coef_valid,
   output logic                               coef_ready,
   input  logic signed [0:3][0:3][COEF_W-1:0] coef,
   input  logic [7:0]                         A,
   input  logic [7:0]                         B,
   input  logic [7:0]                         C,
   input  logic [7:0]                         D,
   input  logic [7:0]                         I,
   input  logic [7:0]                         J,
   input  logic [7:0]                         K,
   input  logic [7:0]                         L,
   input  logic                               mbAddrA_valid,
   input  logic                               mbAddrB_valid,
`ifdef INTRA4X4_DEC_QP_PORT_EN
   input  logic [5:0]                         qp_i,
`endif
   output logic                               recon_valid,
   input  logic                               recon_ready,
   output logic [0:3][0:3][7:0]               recon
);

   state_t                      r_state;
   state_t                      w_state_next;
   logic                        w_accept;

   logic [0:3][0:3][COEF_W-1:0] r_coef;
   logic [7:0]                  r_top  [0:3];
   logic [7:0]                  r_left [0:3];
   logic                        r_a_valid;
   logic                        r_b_valid;
   logic [7:0]                  r_pred;
   logic signed [DEQ_W-1:0]     r_d [0:3][0:3];
   logic signed [TR_W-1:0]      r_t [0:3][0:3];
   logic [0:3][0:3][7:0]        r_recon;

   logic [5:0]                  w_qp;
   logic [3:0]                  w_qp_div;
   logic [2:0]                  w_qp_mod;
   logic [9:0]                  w_sum_top;
   logic [9:0]                  w_sum_left;
   logic [10:0]                 w_sum_all;
   logic [7:0]                  w_pred;
   logic signed [DEQ_W-1:0]     w_d      [0:3][0:3];
   logic signed [TR_W-1:0]      w_x      [0:3][0:3];
   logic signed [TR_W-1:0]      w_y      [0:3][0:3];
   logic signed [TR_W-1:0]      w_t_next [0:3][0:3];
   logic [7:0]                  w_recon  [0:3][0:3];

   // ---------------- control ----------------
   assign coef_ready  = (r_state == IDLE);
   assign recon_valid = (r_state == OUT);
   assign w_accept    = coef_valid && coef_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_state <= IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_state_next = DEQ;
         DEQ:     w_state_next = ROW;
         ROW:     w_state_next = COL;
         COL:     w_state_next = RECON;
         RECON:   w_state_next = OUT;
         OUT:     if (recon_ready) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
      // Soft clear wins over any handshake on the same edge.
      if (h264_reset)
         w_state_next = IDLE;
   end

   // ---------------- quantizer source ----------------
`ifdef INTRA4X4_DEC_QP_PORT_EN
   logic [5:0] r_qp;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         r_qp <= '0;
      else if (h264_reset)
         r_qp <= '0;
      else if (w_accept)
         r_qp <= qp_i;
   end
   assign w_qp = r_qp;
`else
   assign w_qp = DEFAULT_QP;
`endif

   assign w_qp_div = 4'(w_qp / 6'd6);
   assign w_qp_mod = 3'(w_qp % 6'd6);

   // ---------------- DC prediction ----------------
   assign w_sum_top  = 10'(r_top[0]) + 10'(r_top[1]) + 10'(r_top[2]) + 10'(r_top[3]);
   assign w_sum_left = 10'(r_left[0]) + 10'(r_left[1]) + 10'(r_left[2]) + 10'(r_left[3]);
   assign w_sum_all  = 11'(w_sum_top) + 11'(w_sum_left);

   always_comb begin
      w_pred = 8'd128;
      case ({r_a_valid, r_b_valid})
         2'b01:   w_pred = 8'((w_sum_top + 10'd2) >> 2);
         2'b10:   w_pred = 8'((w_sum_left + 10'd2) >> 2);
         2'b11:   w_pred = 8'((w_sum_all + 11'd4) >> 3);
         default: w_pred = 8'd128;
      endcase
   end

   // ---------------- dequant, butterflies, reconstruction ----------------
   genvar gi, gj;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_row
         for (gj = 0; gj < 4; gj++) begin : g_col
            localparam logic [1:0] CLS = pos_class(gi, gj);
            logic signed [TR_W:0] w_rnd;
            logic signed [TR_W:0] w_pix;

            assign w_d[gi][gj] = dequant($signed(r_coef[gi][gj]), LS_TAB[CLS][w_qp_mod], w_qp_div);

            assign w_rnd = ($signed({r_t[gi][gj][TR_W-1], r_t[gi][gj]}) + 21'sd32) >>> 6;
            assign w_pix = w_rnd + $signed({13'd0, r_pred});
            assign w_recon[gi][gj] = (w_pix < 0)   ? 8'd0   :
                                     (w_pix > 255) ? 8'd255 : w_pix[7:0];
         end

         // Instance gi handles row gi in ROW and column gi in COL.
         intra_4x4_idct1d u_idct (
            .i_x0 (w_x[gi][0]),
            .i_x1 (w_x[gi][1]),
            .i_x2 (w_x[gi][2]),
            .i_x3 (w_x[gi][3]),
            .o_y0 (w_y[gi][0]),
            .o_y1 (w_y[gi][1]),
            .o_y2 (w_y[gi][2]),
            .o_y3 (w_y[gi][3])
         );
      end
   endgenerate

   always_comb begin
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            if (r_state == COL)
               w_x[a][b] = r_t[b][a];
            else
               w_x[a][b] = TR_W'(r_d[a][b]);
         end
      end
   end

   always_comb begin
      for (int a = 0; a < 4; a++) begin
         for (int b = 0; b < 4; b++) begin
            if (r_state == COL)
               w_t_next[a][b] = w_y[b][a];
            else
               w_t_next[a][b] = w_y[a][b];
         end
      end
   end

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst || h264_reset) begin
         r_coef    <= '0;
         r_a_valid <= 1'b0;
         r_b_valid <= 1'b0;
         r_pred    <= '0;
         r_recon   <= '0;
         for (int a = 0; a < 4; a++) begin
            r_top[a]  <= '0;
            r_left[a] <= '0;
            for (int b = 0; b < 4; b++) begin
               r_d[a][b] <= '0;
               r_t[a][b] <= '0;
            end
         end
      end else begin
         if (w_accept) begin
            r_coef    <= coef;
            r_top[0]  <= A;
            r_top[1]  <= B;
            r_top[2]  <= C;
            r_top[3]  <= D;
            r_left[0] <= I;
            r_left[1] <= J;
            r_left[2] <= K;
            r_left[3] <= L;
            r_a_valid <= mbAddrA_valid;
            r_b_valid <= mbAddrB_valid;
         end
         if (r_state == DEQ)
            r_pred <= w_pred;
         for (int a = 0; a < 4; a++) begin
            for (int b = 0; b < 4; b++) begin
               if (r_state == DEQ)
                  r_d[a][b] <= w_d[a][b];
               if (r_state == ROW || r_state == COL)
                  r_t[a][b] <= w_t_next[a][b];
               if (r_state == RECON)
                  r_recon[a][b] <= w_recon[a][b];
            end
         end
      end
   end

   assign recon = r_recon;

endmodule

// File: tb/tb_intra_4x4_dec_pe.sv
// -----------------------------------------------------------------------------
// tb_intra_4x4_dec_pe
// Directed and randomized blocks for intra_4x4_dec_pe, checked against an
// integer reference model of prediction, dequant, transform and clipping.
// Build macro: INTRA4X4_DEC_QP_PORT_EN (drives qp_i and randomizes qp).
// -----------------------------------------------------------------------------
module tb_intra_4x4_dec_pe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic h264_reset = 1'b0;
   logic coef_valid = 1'b0;
   logic recon_ready = 1'b0;
   logic mbAddrA_valid = 1'b0;
   logic mbAddrB_valid = 1'b0;
   logic signed [0:3][0:3][14:0] coef = '0;
   logic [7:0] A = '0, B = '0, C = '0, D = '0, I = '0, J = '0, K = '0, L = '0;
   logic coef_ready;
   logic recon_valid;
   logic [0:3][0:3][7:0] recon;
`ifdef INTRA4X4_DEC_QP_PORT_EN
   logic [5:0] qp_i = 6'd27;
`endif

   int checks = 0;
   int failures = 0;

   // Reference model state
   int m_coef [4][4];
   int m_top [4];
   int m_left [4];
   bit m_av, m_bv;
   int m_qp = 27;
   int exp_pred;
   logic [0:3][0:3][7:0] exp_recon;
   int LS_M [3][6] = '{'{10, 11, 13, 14, 16, 18},
                       '{16, 18, 20, 23, 25, 29},
                       '{13, 14, 16, 18, 20, 23}};

   intra_4x4_dec_pe dut (
      .clk           (clk),
      .rst           (rst),
      .h264_reset    (h264_reset),
      .coef_valid    (coef_valid),
      .coef_ready    (coef_ready),
      .coef          (coef),
      .A             (A),
      .B             (B),
      .C             (C),
      .D             (D),
      .I             (I),
      .J             (J),
      .K             (K),
      .L             (L),
      .mbAddrA_valid (mbAddrA_valid),
      .mbAddrB_valid (mbAddrB_valid),
`ifdef INTRA4X4_DEC_QP_PORT_EN
      .qp_i          (qp_i),
`endif
      .recon_valid   (recon_valid),
      .recon_ready   (recon_ready),
      .recon         (recon)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [135:0] obs, input logic [135:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic bfly(input int x0, input int x1, input int x2, input int x3,
                       output int y0, output int y1, output int y2, output int y3);
      int e0, e1, e2, e3;
      e0 = x0 + x2;
      e1 = x0 - x2;
      e2 = (x1 >>> 1) - x3;
      e3 = x1 + (x3 >>> 1);
      y0 = e0 + e3;
      y1 = e1 + e2;
      y2 = e1 - e2;
      y3 = e0 - e3;
   endtask

   task automatic compute_model();
      int d [4][4];
      int t [4][4];
      int u [4][4];
      int st, sl, cls, v, p;
      st = m_top[0] + m_top[1] + m_top[2] + m_top[3];
      sl = m_left[0] + m_left[1] + m_left[2] + m_left[3];
      if (!m_av && !m_bv)     exp_pred = 128;
      else if (!m_av)         exp_pred = (st + 2) / 4;
      else if (!m_bv)         exp_pred = (sl + 2) / 4;
      else                    exp_pred = (st + sl + 4) / 8;
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            if (i % 2 == 0 && j % 2 == 0)      cls = 0;
            else if (i % 2 == 1 && j % 2 == 1) cls = 1;
            else                               cls = 2;
            v = m_coef[i][j] * LS_M[cls][m_qp % 6] * (1 << (m_qp / 6));
            if (v > 32767)  v = 32767;
            if (v < -32768) v = -32768;
            d[i][j] = v;
         end
      for (int i = 0; i < 4; i++)
         bfly(d[i][0], d[i][1], d[i][2], d[i][3], t[i][0], t[i][1], t[i][2], t[i][3]);
      for (int j = 0; j < 4; j++)
         bfly(t[0][j], t[1][j], t[2][j], t[3][j], u[0][j], u[1][j], u[2][j], u[3][j]);
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) begin
            p = exp_pred + ((u[i][j] + 32) >>> 6);
            if (p < 0)   p = 0;
            if (p > 255) p = 255;
            exp_recon[i][j] = 8'(p);
         end
   endtask

   task automatic clear_stim();
      for (int i = 0; i < 4; i++) begin
         m_top[i] = 0;
         m_left[i] = 0;
         for (int j = 0; j < 4; j++) m_coef[i][j] = 0;
      end
      m_av = 1'b0;
      m_bv = 1'b0;
      m_qp = 27;
   endtask

   task automatic drive_inputs();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) coef[i][j] = 15'(m_coef[i][j]);
      A = 8'(m_top[0]);  B = 8'(m_top[1]);  C = 8'(m_top[2]);  D = 8'(m_top[3]);
      I = 8'(m_left[0]); J = 8'(m_left[1]); K = 8'(m_left[2]); L = 8'(m_left[3]);
      mbAddrA_valid = m_av;
      mbAddrB_valid = m_bv;
`ifdef INTRA4X4_DEC_QP_PORT_EN
      qp_i = 6'(m_qp);
`endif
   endtask

   // Garbage on the inputs once the block is captured.
   task automatic scramble_inputs();
      for (int i = 0; i < 4; i++)
         for (int j = 0; j < 4; j++) coef[i][j] = 15'($urandom);
      {A, B, C, D} = $urandom;
      {I, J, K, L} = $urandom;
      mbAddrA_valid = 1'($urandom);
      mbAddrB_valid = 1'($urandom);
   endtask

   // One block: accept edge E0 puts the DUT in DEQ; recon_valid must stay low
   // after E1..E3 and be high after E4 (OUT, the fifth cycle counting the
   // accept cycle). poke drives coef_valid during the output stall.
   task automatic do_block(input string tag, input int stall, input bit poke);
      bit seen;
      compute_model();
      @(negedge clk);
      drive_inputs();
      coef_valid = 1'b1;
      recon_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, ".busy"}, 136'(coef_ready), 136'(0));
      @(negedge clk);
      coef_valid = 1'b0;
      scramble_inputs();
      for (int e = 1; e <= 3; e++) begin
         @(posedge clk); #1;
         check({tag, ".early"}, 136'(recon_valid), 136'(0));
      end
      @(posedge clk); #1;
      check({tag, ".valid"}, 136'(recon_valid), 136'(1));
      check({tag, ".recon"}, 136'(recon), 136'(exp_recon));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         if (poke) begin
            scramble_inputs();
            coef_valid = 1'b1;
         end
         @(posedge clk); #1;
         check({tag, ".hold"}, {6'd0, recon_valid, coef_ready, recon}, {6'd0, 1'b1, 1'b0, exp_recon});
      end
      @(negedge clk);
      recon_ready = 1'b1;
      coef_valid = 1'b0;
      @(posedge clk); #1;
      check({tag, ".release"}, 136'({recon_valid, coef_ready}), 136'(2'b01));
      @(negedge clk);
      recon_ready = 1'b0;
      if (poke) begin
         seen = 1'b0;
         repeat (6) begin
            @(posedge clk); #1;
            seen |= recon_valid;
         end
         check({tag, ".no_phantom"}, 136'(seen), 136'(0));
      end
      $display("txn %s a_valid=%0d b_valid=%0d qp=%0d stall=%0d pred=%0d recon00=%0d exp00=%0d",
               tag, m_av, m_bv, m_qp, stall, exp_pred, recon[0][0], exp_recon[0][0]);
   endtask

   // Starts a block and leaves it in ROW (after E1), returning at #1 past E1.
   task automatic start_to_row();
      @(negedge clk);
      drive_inputs();
      coef_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      coef_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic expect_quiet(input string tag);
      bit seen;
      seen = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         seen |= recon_valid;
      end
      check({tag, ".no_valid"}, 136'({seen, coef_ready}), 136'(2'b01));
   endtask

   initial begin
      // ---------------- power-on reset ----------------
      #1 rst = 1'b0;
      repeat (2) @(negedge clk);
      check("reset.outputs", {6'd0, recon_valid, coef_ready, recon}, {6'd0, 1'b0, 1'b1, 128'd0});
      rst = 1'b1;
      #1;
      check("reset.ready_after", 136'(coef_ready), 136'(1));

      // ---------------- directed blocks ----------------
      clear_stim();
      do_block("dc128_zero", 0, 1'b0);
      check("dc128_zero.const", 136'(recon), 136'({16{8'd128}}));

      clear_stim();
      m_bv = 1'b1;
      m_top = '{100, 102, 104, 106};
      do_block("top_only", 1, 1'b0);
      check("top_only.const", 136'(recon), 136'({16{8'd103}}));

      clear_stim();
      m_av = 1'b1;
      m_left = '{10, 10, 10, 11};
      do_block("left_only", 0, 1'b0);
      check("left_only.const", 136'(recon), 136'({16{8'd10}}));

      clear_stim();
      m_coef[0][0] = 1;
      do_block("dc_plus1", 0, 1'b0);
      check("dc_plus1.const", 136'(recon), 136'({16{8'd132}}));

      clear_stim();
      m_coef[0][0] = 100;
      do_block("clip_hi", 0, 1'b0);
      check("clip_hi.const", 136'(recon), 136'({16{8'd255}}));

      clear_stim();
      m_coef[0][0] = -100;
      do_block("clip_lo", 0, 1'b0);
      check("clip_lo.const", 136'(recon), 136'({16{8'd0}}));

      // Output stall with new coef_valid offered the whole time
      clear_stim();
      do_block("stall_poke", 10, 1'b1);

      // ---------------- async reset during ROW ----------------
      clear_stim();
      m_coef[1][2] = 7;
      start_to_row();
      #1 rst = 1'b0;
      #1;
      check("rst_row.cleared", {6'd0, recon_valid, coef_ready, recon}, {6'd0, 1'b0, 1'b1, 128'd0});
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rst_row.ready", 136'(coef_ready), 136'(1));
      expect_quiet("rst_row");

      // ---------------- soft clear during ROW ----------------
      clear_stim();
      m_bv = 1'b1;
      m_top = '{100, 102, 104, 106};
      do_block("pre_soft", 0, 1'b0);
      clear_stim();
      m_coef[0][1] = -5;
      start_to_row();
      @(negedge clk);
      h264_reset = 1'b1;
      @(posedge clk); #1;
      check("soft_row.cleared", {6'd0, recon_valid, coef_ready, recon}, {6'd0, 1'b0, 1'b1, 128'd0});
      @(negedge clk);
      h264_reset = 1'b0;
      expect_quiet("soft_row");

      // Soft clear on the same edge as an offered block: nothing accepted
      clear_stim();
      @(negedge clk);
      drive_inputs();
      coef_valid = 1'b1;
      h264_reset = 1'b1;
      @(posedge clk); #1;
      check("soft_accept.ready", 136'(coef_ready), 136'(1));
      @(negedge clk);
      coef_valid = 1'b0;
      h264_reset = 1'b0;
      expect_quiet("soft_accept");

      // ---------------- randomized blocks ----------------
      for (int n = 0; n < 24; n++) begin
         clear_stim();
         m_av = 1'($urandom);
         m_bv = 1'($urandom);
         for (int i = 0; i < 4; i++) begin
            m_top[i]  = int'($urandom_range(0, 255));
            m_left[i] = int'($urandom_range(0, 255));
            for (int j = 0; j < 4; j++) begin
               if ($urandom_range(0, 3) == 0)
                  m_coef[i][j] = int'($urandom_range(0, 32767)) - 16384;
               else
                  m_coef[i][j] = int'($urandom_range(0, 64)) - 32;
            end
         end
`ifdef INTRA4X4_DEC_QP_PORT_EN
         m_qp = int'($urandom_range(0, 51));
`endif
         do_block($sformatf("rand%0d", n), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
